// File: rtl/fcl_fp_pkg.sv
// Shared types and helpers for the fcl_fp fully-connected layer engine.
//   state_t   : engine control states IDLE -> ACC -> FIN -> OUT
//   *_DEF     : default parameter values for the engine
//   sat_shift : arithmetic right shift (floor) followed by signed saturation
package fcl_fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN,
    OUT
  } state_t;

  localparam int unsigned DATAWIDTH_DEF    = 16;
  localparam int unsigned PARALLEL_NUM_DEF = 4;
  localparam int unsigned MAX_LEN_DEF      = 1024;

  // Widest accumulator / result the helper supports; callers sign-extend
  // into and truncate out of these with explicit casts.
  localparam int unsigned ACC_MAX = 128;
  localparam int unsigned DW_MAX  = 64;

  // Shift acc right by sh (floor), then clamp to the signed dw-bit range.
  function automatic logic signed [DW_MAX-1:0] sat_shift(
    input logic signed [ACC_MAX-1:0] acc,
    input int unsigned               sh,
    input int unsigned               dw
  );
    logic signed [ACC_MAX-1:0] one;
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    logic signed [ACC_MAX-1:0] s;
    one    = '0;
    one[0] = 1'b1;
    s  = acc >>> sh;
    hi = (one <<< (dw - 1)) - one;
    lo = '0 - (one <<< (dw - 1));
    if (s > hi)      return DW_MAX'(hi);
    else if (s < lo) return DW_MAX'(lo);
    else             return DW_MAX'(s);
  endfunction

endpackage

// File: rtl/fcl_fp_mac_lane.sv
// One multiply-accumulate lane of the fcl_fp engine.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : synchronous accumulator clear (wins over en)
//   en       : add INPUT*W to the accumulator this edge
//   INPUT, W : signed activation and weight
//   acc      : signed running sum
module fcl_fp_mac_lane #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ACC_WIDTH = 42
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [DATAWIDTH-1:0] INPUT,
  input  logic signed [DATAWIDTH-1:0] W,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*DATAWIDTH-1:0] prod;

  assign prod = INPUT * W;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/fcl_fp_engine.sv
// Job-based fixed-point fully-connected layer engine.
// Each job accepts cfg_len beats (one activation broadcast to all lanes plus
// one weight per lane), accumulates per lane, then shifts, saturates and
// presents PARALLEL_NUM results on a held valid/ready output.
//   clk, rst            : clock, asynchronous active-low reset
//   start, cfg_len,     : job request (IDLE only), beat count and right
//   shift                 shift, both latched at start
//   abort               : synchronous cancel back to IDLE, highest priority
//   in_valid/in_ready,  : input beat stream
//   INPUT, W
//   out_valid/out_ready,: result handshake, OUTPUT held until taken
//   OUTPUT
//   busy                : engine not idle
// Optional build macro FCL_FP_RELU_EN: clamp negative lane results to zero.
module fcl_fp_engine
  import fcl_fp_pkg::*;
#(
  parameter  int unsigned DATAWIDTH    = DATAWIDTH_DEF,
  parameter  int unsigned PARALLEL_NUM = PARALLEL_NUM_DEF,
  parameter  int unsigned MAX_LEN      = MAX_LEN_DEF,
  localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1),
  localparam int unsigned ACC_WIDTH    = 2 * DATAWIDTH + $clog2(MAX_LEN),
  localparam int unsigned SHIFT_W      = $clog2(ACC_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [LEN_W-1:0]                      cfg_len,
  input  logic [SHIFT_W-1:0]                    shift,
  input  logic                                  abort,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATAWIDTH-1:0]                  INPUT,
  input  logic [PARALLEL_NUM-1:0][DATAWIDTH-1:0] W,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PARALLEL_NUM-1:0][DATAWIDTH-1:0] OUTPUT,
  output logic                                  busy
);

  state_t                                 state, state_nxt;
  logic [LEN_W-1:0]                       len_q;
  logic [LEN_W-1:0]                       cnt;
  logic [SHIFT_W-1:0]                     shift_q;
  logic                                   start_job;
  logic                                   beat;
  logic                                   last_beat;
  logic                                   acc_clear;
  logic signed [ACC_WIDTH-1:0]            acc [PARALLEL_NUM];
  logic [PARALLEL_NUM-1:0][DATAWIDTH-1:0] res;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  // abort masks both the job request and the beat handshake
  assign start_job = (state == IDLE) && start && !abort;
  assign beat      = in_valid && in_ready && !abort;
  assign last_beat = (cnt == len_q - LEN_W'(1));
  assign acc_clear = abort || start_job;

  for (genvar g = 0; g < PARALLEL_NUM; g++) begin : g_lane
    fcl_fp_mac_lane #(
      .DATAWIDTH(DATAWIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clear(acc_clear),
      .en   (beat),
      .INPUT(INPUT),
      .W    (W[g]),
      .acc  (acc[g])
    );
  end

  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < PARALLEL_NUM; i++) begin
      res[i] = DATAWIDTH'(sat_shift(ACC_MAX'(acc[i]), 32'(shift_q), DATAWIDTH));
`ifdef FCL_FP_RELU_EN
      if (res[i][DATAWIDTH-1]) res[i] = '0;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (cfg_len == '0) ? FIN : ACC;
      ACC:  if (beat && last_beat) state_nxt = FIN;
      FIN:  state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      shift_q <= '0;
      cnt     <= '0;
      OUTPUT  <= '0;
    end else begin
      if (start_job) begin
        len_q   <= cfg_len;
        shift_q <= shift;
      end
      if (acc_clear)  cnt <= '0;
      else if (beat)  cnt <= cnt + LEN_W'(1);
      if (state == FIN && !abort) OUTPUT <= res;
    end
  end

endmodule

// File: tb/tb_fcl_fp_engine.sv
module tb_fcl_fp_engine;

  localparam int DW = 16;
  localparam int PN = 4;
  localparam int ML = 1024;
  localparam int LW = 11;
  localparam int SW = 6;

  typedef logic [PN-1:0][DW-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LW-1:0]    cfg_len;
  logic [SW-1:0]    shift;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    INPUT;
  vec_t             W;
  logic             out_valid;
  logic             out_ready;
  vec_t             OUTPUT;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;

  vec_t          exp_q[$];
  logic [DW-1:0] b_in[$];
  vec_t          b_w[$];
  vec_t          last_exp;

  fcl_fp_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_len  (cfg_len),
    .shift    (shift),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .INPUT    (INPUT),
    .W        (W),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUTPUT   (OUTPUT),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: compare on every rising edge of out_valid.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", OUTPUT);
        end else begin
          chk("result", 64'(OUTPUT), 64'(exp_q.pop_front()));
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // All drivers below run #1 after a rising edge.
  task automatic send_beat(input logic [DW-1:0] x, input vec_t w, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    INPUT    = x;
    W        = w;
    chk("in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_job(input int len, input int sh, input bit gaps, input int stall,
                        input vec_t exp, input bit hold_start);
    exp_q.push_back(exp);
    start   = 1'b1;
    cfg_len = LW'(len);
    shift   = SW'(sh);
    @(posedge clk); #1;
    start   = 1'b0;
    cfg_len = LW'(3);
    shift   = SW'(7);
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int b = 0; b < len; b++)
      send_beat(b_in[b], b_w[b], gaps ? int'($urandom_range(0, 2)) : 0);
    chk("lat_lo", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_hi", 64'(out_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_out", 64'(OUTPUT), 64'(exp));
    end
    out_ready = 1'b1;
    start     = hold_start;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("taken_valid", 64'(out_valid), 64'd0);
    chk("taken_busy", 64'(busy), 64'd0);
    b_in.delete();
    b_w.delete();
    last_exp = exp;
  endtask

  initial begin
    vec_t e;
    rst = 1'b0; start = 1'b0; cfg_len = '0; shift = '0; abort = 1'b0;
    in_valid = 1'b0; INPUT = '0; W = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_output", 64'(OUTPUT), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic: 2+3+4 = 9 on every lane
    b_in.push_back(16'd2); b_w.push_back({4{16'd1}});
    b_in.push_back(16'd3); b_w.push_back({4{16'd1}});
    b_in.push_back(16'd4); b_w.push_back({4{16'd1}});
    do_job(3, 0, 1'b0, 0, {4{16'd9}}, 1'b0);

    // Positive saturation
    repeat (4) begin b_in.push_back(16'h7FFF); b_w.push_back({4{16'h7FFF}}); end
    do_job(4, 0, 1'b0, 0, {4{16'h7FFF}}, 1'b0);

    // Negative saturation
    repeat (4) begin b_in.push_back(16'h7FFF); b_w.push_back({4{16'h8000}}); end
`ifdef FCL_FP_RELU_EN
    e = '0;
`else
    e = {4{16'h8000}};
`endif
    do_job(4, 0, 1'b0, 0, e, 1'b0);

    // Shift with floor: -5*{1,2,3,4} >>> 1 = {-3,-5,-8,-10}
    b_in.push_back(16'hFFFB); b_w.push_back({16'd4, 16'd3, 16'd2, 16'd1});
`ifdef FCL_FP_RELU_EN
    e = '0;
`else
    e = {16'hFFF6, 16'hFFF8, 16'hFFFB, 16'hFFFD};
`endif
    do_job(1, 1, 1'b0, 0, e, 1'b0);

    // Input gaps and output stall: W lanes {1,-1,2,0} -> {9,-9,18,0}
    b_in.push_back(16'd2); b_w.push_back({16'd0, 16'd2, 16'hFFFF, 16'd1});
    b_in.push_back(16'd3); b_w.push_back({16'd0, 16'd2, 16'hFFFF, 16'd1});
    b_in.push_back(16'd4); b_w.push_back({16'd0, 16'd2, 16'hFFFF, 16'd1});
`ifdef FCL_FP_RELU_EN
    e = {16'h0000, 16'h0012, 16'h0000, 16'h0009};
`else
    e = {16'h0000, 16'h0012, 16'hFFF7, 16'h0009};
`endif
    do_job(3, 0, 1'b1, 5, e, 1'b0);

    // Abort after 2 of 5 beats, with a beat offered in the abort cycle
    start = 1'b1; cfg_len = LW'(5); shift = '0;
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(16'd3, {4{16'd2}}, 0);
    send_beat(16'd3, {4{16'd2}}, 0);
    abort = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_output_kept", 64'(OUTPUT), 64'(last_exp));

    b_in.push_back(16'd1); b_w.push_back({4{16'd7}});
    do_job(1, 0, 1'b0, 0, {4{16'd7}}, 1'b0);

    // Reset mid-accumulation
    start = 1'b1; cfg_len = LW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(16'd1, {4{16'd5}}, 0);
    rst = 1'b0;
    #1;
    chk("midrst_output", 64'(OUTPUT), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-length job, start held during the take cycle must be ignored
    do_job(0, 0, 1'b0, 0, '0, 1'b1);

    // Longest job at most-negative operands: sum 2^40 saturates high
    for (int b = 0; b < ML; b++) begin
      b_in.push_back(16'h8000);
      b_w.push_back({4{16'h8000}});
    end
    do_job(ML, 0, 1'b0, 0, {4{16'h7FFF}}, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
